// File: rtl/board_renderer_pkg.sv
// Shared board geometry, bus types and helpers for the board renderer.
package board_renderer_pkg;

    localparam int unsigned BOARD_SIZE        = 64;
    localparam int unsigned LOG_BOARD_SIZE    = 6;
    localparam int unsigned WORD_SIZE         = 16;
    localparam int unsigned LOG_WORD_SIZE     = 4;
    localparam int unsigned WORDS_PER_ROW     = BOARD_SIZE / WORD_SIZE;
    localparam int unsigned LOG_WORDS_PER_ROW = LOG_BOARD_SIZE - LOG_WORD_SIZE;
    localparam int unsigned LOG_MAX_ADDR      = 2 * LOG_BOARD_SIZE - LOG_WORD_SIZE;
    localparam int unsigned HCOUNT_W          = 11;
    localparam int unsigned VCOUNT_W          = 10;
    localparam int unsigned COLOR_W           = 12;

    typedef logic [LOG_BOARD_SIZE-1:0]    pos_t;
    typedef logic [LOG_MAX_ADDR-1:0]      addr_t;
    typedef logic [WORD_SIZE-1:0]         word_t;
    typedef logic [LOG_WORDS_PER_ROW-1:0] widx_t;
    typedef logic [LOG_WORD_SIZE-1:0]     bit_idx_t;
    typedef logic [COLOR_W-1:0]           color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } fetch_state_t;

    // First pipeline stage payload: everything the pixel select needs one cycle later.
    typedef struct packed {
        bit_idx_t bit_idx;
        logic     in_board;
        logic     cursor;
        logic     hsync;
        logic     vsync;
        logic     blank;
    } stage1_t;

    // Word address of word widx in board row cy (rows are WORDS_PER_ROW words wide).
    function automatic addr_t row_word_addr(input pos_t cy, input widx_t widx);
        return addr_t'({cy, widx});
    endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Read port of the board double buffer as seen by the renderer.
interface board_renderer_if;
    import board_renderer_pkg::*;

    addr_t addr_r_out;
    word_t data_r_in;

    modport master (output addr_r_out, input data_r_in);
    modport slave  (input addr_r_out, output data_r_in);
endinterface

// File: rtl/board_renderer_prefetch.sv
// Two-word prefetch: fetch FSM, current/next word registers and underflow flag.
module renderer_prefetch
    import board_renderer_pkg::*;
(
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  line_start,
    input  logic  word_start,
    input  logic  last_word,
    input  addr_t req_addr,
    input  word_t data_r_in,
    output addr_t addr_r_out,
    output word_t cur_word,
    output logic  underflow_out
);

    fetch_state_t state, state_nxt;
    word_t        nxt_word;
    logic         nxt_valid;
    logic         line_active;
    logic         swap_c;
    logic         req_c;
    logic         fetch_c;
    logic         capture_c;

    // Boundaries only count once a line start has been seen since reset.
    assign swap_c = word_start && line_active;
    assign req_c  = line_start || (swap_c && !last_word);

    // Fetch FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Fetch FSM next state: issue in IDLE, capture read data two cycles later.
    always_comb begin
        state_nxt = state;
        fetch_c   = 1'b0;
        capture_c = 1'b0;
        case (state)
            IDLE: begin
                if (req_c) begin
                    fetch_c   = 1'b1;
                    state_nxt = WAIT1;
                end
            end
            WAIT1: state_nxt = WAIT2;
            WAIT2: begin
                capture_c = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word registers; the boundary swap is last so it wins over a same-cycle capture.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_r_out    <= '0;
            nxt_word      <= '0;
            nxt_valid     <= 1'b0;
            cur_word      <= '0;
            underflow_out <= 1'b0;
            line_active   <= 1'b0;
        end else begin
            if (line_start) line_active <= 1'b1;
            if (fetch_c)    addr_r_out  <= req_addr;
            if (capture_c) begin
                nxt_word  <= data_r_in;
                nxt_valid <= 1'b1;
            end
            if (swap_c) begin
                cur_word  <= nxt_valid ? nxt_word : '0;
                nxt_valid <= 1'b0;
                if (!nxt_valid) underflow_out <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_renderer.sv
// Raster-tracking board reader: prefetches words ahead of the beam and paints scaled cells.
module board_renderer
    import board_renderer_pkg::*;
#(
    parameter int unsigned LOG_CELL_PX  = 2,
    parameter int unsigned X_OFFSET     = 64,
    parameter int unsigned Y_OFFSET     = 16,
    parameter color_t      ALIVE_COLOR  = 12'hFFF,
    parameter color_t      DEAD_COLOR   = 12'h222,
    parameter color_t      CURSOR_COLOR = 12'hF00
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    input  logic                hsync_in,
    input  logic                vsync_in,
    input  logic                blank_in,
    input  pos_t                cursor_x_in,
    input  pos_t                cursor_y_in,
    board_renderer_if.master    mem,
    output color_t              pixel_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                blank_out,
    output logic                underflow_out
);

    localparam int unsigned PX          = BOARD_SIZE << LOG_CELL_PX;
    localparam int unsigned WORD_PX_LOG = LOG_WORD_SIZE + LOG_CELL_PX;
    localparam stage1_t     S1_RESET    = '{bit_idx: '0, in_board: 1'b0, cursor: 1'b0,
                                            hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

    logic [HCOUNT_W-1:0] hx_c;
    logic [HCOUNT_W-1:0] vy_c;
    logic                h_in_c;
    logic                v_in_c;
    logic                in_board_c;
    pos_t                cx_c;
    pos_t                cy_c;
    widx_t               widx_c;
    logic                word_start_c;
    logic                line_start_c;
    logic                last_word_c;
    addr_t               req_addr_c;
    word_t               cur_word;
    stage1_t             s1;
    color_t              pixel_c;

    // Board-relative coordinates; out-of-region wraparound is masked by in_board.
    assign hx_c       = hcount_in - HCOUNT_W'(X_OFFSET);
    assign vy_c       = HCOUNT_W'(vcount_in) - HCOUNT_W'(Y_OFFSET);
    assign h_in_c     = (hcount_in >= HCOUNT_W'(X_OFFSET)) && (hx_c < HCOUNT_W'(PX));
    assign v_in_c     = (HCOUNT_W'(vcount_in) >= HCOUNT_W'(Y_OFFSET)) && (vy_c < HCOUNT_W'(PX));
    assign in_board_c = h_in_c && v_in_c;
    assign cx_c       = pos_t'(hx_c >> LOG_CELL_PX);
    assign cy_c       = pos_t'(vy_c >> LOG_CELL_PX);
    assign widx_c     = widx_t'(cx_c >> LOG_WORD_SIZE);

    // Fetch triggers: line start four pixels early, then one per word boundary.
    assign line_start_c = v_in_c && (hcount_in == HCOUNT_W'(X_OFFSET - 4));
    assign word_start_c = in_board_c && (hx_c[WORD_PX_LOG-1:0] == '0);
    assign last_word_c  = (widx_c == widx_t'(WORDS_PER_ROW - 1));
    assign req_addr_c   = line_start_c ? row_word_addr(cy_c, '0)
                                       : row_word_addr(cy_c, widx_t'(widx_c + 1'b1));

    renderer_prefetch u_prefetch (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .line_start    (line_start_c),
        .word_start    (word_start_c),
        .last_word     (last_word_c),
        .req_addr      (req_addr_c),
        .data_r_in     (mem.data_r_in),
        .addr_r_out    (mem.addr_r_out),
        .cur_word      (cur_word),
        .underflow_out (underflow_out)
    );

    // Stage 1: register cell bit position, region, cursor match and raw timing.
    // Lowest x sits in the MSB, so the bit index is the inverted cell offset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1 <= S1_RESET;
        end else begin
            s1.bit_idx  <= ~cx_c[LOG_WORD_SIZE-1:0];
            s1.in_board <= in_board_c;
            s1.cursor   <= (cx_c == cursor_x_in) && (cy_c == cursor_y_in);
            s1.hsync    <= hsync_in;
            s1.vsync    <= vsync_in;
            s1.blank    <= blank_in;
        end
    end

    // Pixel colour priority: blank, off-board, cursor, live, dead.
    always_comb begin
        pixel_c = '0;
        if (!s1.blank && s1.in_board) begin
            if (s1.cursor)                 pixel_c = CURSOR_COLOR;
            else if (cur_word[s1.bit_idx]) pixel_c = ALIVE_COLOR;
            else                           pixel_c = DEAD_COLOR;
        end
    end

    // Stage 2: output registers, two cycles behind the timing inputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_out <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            blank_out <= 1'b1;
        end else begin
            pixel_out <= pixel_c;
            hsync_out <= s1.hsync;
            vsync_out <= s1.vsync;
            blank_out <= s1.blank;
        end
    end

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: raster driver, memory model, pixel scoreboard.
module tb_board_renderer;
    import board_renderer_pkg::*;

    localparam int H_TOTAL = 400;

    typedef struct packed {
        color_t pixel;
        logic   hs;
        logic   vs;
        logic   bl;
    } vid_t;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic          hsync_in;
    logic          vsync_in;
    logic          blank_in;
    pos_t          cursor_x_in;
    pos_t          cursor_y_in;
    color_t        pixel_out;
    logic          hsync_out;
    logic          vsync_out;
    logic          blank_out;
    logic          underflow_out;

    board_renderer_if mem_if();
    word_t mem [256];

    vid_t  exp_q [$];
    vid_t  obs_q [$];
    int    addr_h_q [$];
    addr_t addr_v_q [$];
    int    total = 0;
    int    bad   = 0;

    board_renderer #(
        .LOG_CELL_PX  (2),
        .X_OFFSET     (64),
        .Y_OFFSET     (16),
        .ALIVE_COLOR  (12'hFFF),
        .DEAD_COLOR   (12'h222),
        .CURSOR_COLOR (12'hF00)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .blank_in      (blank_in),
        .cursor_x_in   (cursor_x_in),
        .cursor_y_in   (cursor_y_in),
        .mem           (mem_if),
        .pixel_out     (pixel_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .blank_out     (blank_out),
        .underflow_out (underflow_out)
    );

    always #5 clk_in = ~clk_in;

    // Memory with data valid on the second edge after the address changes.
    always_ff @(posedge clk_in) mem_if.data_r_in <= mem[mem_if.addr_r_out];

    // Reference pixel; zmask marks row words the renderer is expected to show as zero.
    function automatic color_t model_pixel(input int h, input int v, input logic bl,
                                           input logic [3:0] zmask);
        int    cx, cy, w;
        word_t word;
        if (bl) return 12'h000;
        if (h < 64 || h >= 320 || v < 16 || v >= 272) return 12'h000;
        cx = (h - 64) / 4;
        cy = (v - 16) / 4;
        if (cx == int'(cursor_x_in) && cy == int'(cursor_y_in)) return 12'hF00;
        w    = cx / 16;
        word = zmask[w] ? 16'h0000 : mem[cy * 4 + w];
        return word[15 - (cx % 16)] ? 12'hFFF : 12'h222;
    endfunction

    task automatic tick(input int h, input int v, input logic hs, input logic vs,
                        input logic bl, input logic [3:0] zmask);
        vid_t e, o;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        hsync_in  = hs;
        vsync_in  = vs;
        blank_in  = bl;
        e.pixel = model_pixel(h, v, bl, zmask);
        e.hs    = hs;
        e.vs    = vs;
        e.bl    = bl;
        exp_q.push_back(e);
        @(posedge clk_in);
        #1;
        addr_h_q.push_back(h);
        addr_v_q.push_back(mem_if.addr_r_out);
        if (exp_q.size() >= 2) begin
            o.pixel = pixel_out;
            o.hs    = hsync_out;
            o.vs    = vsync_out;
            o.bl    = blank_out;
            obs_q.push_back(o);
        end
    endtask

    task automatic run_line(input int v, input int h0, input logic [3:0] zmask);
        for (int h = h0; h < H_TOTAL; h++)
            tick(h, v, (h >= 345 && h < 375) ? 1'b0 : 1'b1, 1'b1, (h >= 330), zmask);
    endtask

    task automatic do_reset(input int h, input int v);
        rst_in    = 1'b1;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        exp_q.delete();
        obs_q.delete();
        addr_h_q.delete();
        addr_v_q.delete();
    endtask

    task automatic test_reset();
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        blank_in = 1'b0;
        do_reset(100, 16);
        total++; if (pixel_out !== 12'h000) begin bad++; $display("FAIL reset_pixel: got %h exp 000", pixel_out); end
        total++; if (hsync_out !== 1'b1) begin bad++; $display("FAIL reset_hsync: got %b exp 1", hsync_out); end
        total++; if (vsync_out !== 1'b1) begin bad++; $display("FAIL reset_vsync: got %b exp 1", vsync_out); end
        total++; if (blank_out !== 1'b1) begin bad++; $display("FAIL reset_blank: got %b exp 1", blank_out); end
        total++; if (underflow_out !== 1'b0) begin bad++; $display("FAIL reset_underflow: got %b exp 0", underflow_out); end
        total++; if (mem_if.addr_r_out !== 8'd0) begin bad++; $display("FAIL reset_addr: got %0d exp 0", mem_if.addr_r_out); end
    endtask

    task automatic test_pattern();
        vid_t e, o;
        for (int k = 0; k < 256; k++) mem[k] = 16'h8001;
        cursor_x_in = 6'd63;
        cursor_y_in = 6'd63;
        run_line(16, 0, 4'b0000);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL pattern_px: got %h exp %h", o, e); end
        end
        total++; if (underflow_out !== 1'b0) begin bad++; $display("FAIL pattern_underflow: got %b exp 0", underflow_out); end
    endtask

    task automatic test_row_addr();
        vid_t  e, o;
        addr_t prev;
        int    n;
        int    exp_h [4] = '{60, 64, 128, 192};
        int    exp_a [4] = '{4, 5, 6, 7};
        int    got_h [4];
        int    got_a [4];
        for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
        prev = mem_if.addr_r_out;
        addr_h_q.delete();
        addr_v_q.delete();
        run_line(20, 0, 4'b0000);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL row_addr_px: got %h exp %h", o, e); end
        end
        n = 0;
        for (int i = 0; i < addr_v_q.size(); i++) begin
            if (addr_v_q[i] !== prev) begin
                if (n < 4) begin
                    got_h[n] = addr_h_q[i];
                    got_a[n] = int'(addr_v_q[i]);
                end
                n++;
                prev = addr_v_q[i];
            end
        end
        total++; if (n != 4) begin bad++; $display("FAIL row_addr_count: got %0d exp 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            total++;
            if (got_h[i] != exp_h[i] || got_a[i] != exp_a[i]) begin
                bad++;
                $display("FAIL row_addr_seq[%0d]: got addr %0d at h=%0d exp addr %0d at h=%0d",
                         i, got_a[i], got_h[i], exp_a[i], exp_h[i]);
            end
        end
    endtask

    task automatic test_cursor();
        vid_t e, o;
        int   lines [4] = '{15, 16, 19, 20};
        for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
        cursor_x_in = 6'd0;
        cursor_y_in = 6'd0;
        foreach (lines[i]) run_line(lines[i], 0, 4'b0000);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL cursor_px: got %h exp %h", o, e); end
        end
    endtask

    task automatic test_sync_pass();
        vid_t e, o;
        for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
        cursor_x_in = 6'd20;
        cursor_y_in = 6'd0;
        for (int h = 0; h < H_TOTAL; h++)
            tick(h, 17, 1'($urandom), 1'($urandom), 1'($urandom), 4'b0000);
        for (int h = 0; h < H_TOTAL; h++)
            tick(h, 300, 1'($urandom), 1'($urandom), 1'($urandom), 4'b0000);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL sync_pass: got %h exp %h", o, e); end
        end
    endtask

    task automatic test_edges();
        vid_t  e, o;
        addr_t a_before;
        for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
        cursor_x_in = 6'd63;
        cursor_y_in = 6'd63;
        run_line(271, 0, 4'b0000);
        a_before = mem_if.addr_r_out;
        total++; if (a_before !== 8'd255) begin bad++; $display("FAIL last_row_addr: got %0d exp 255", a_before); end
        run_line(272, 0, 4'b0000);
        total++; if (mem_if.addr_r_out !== 8'd255) begin bad++; $display("FAIL no_fetch_outside: got %0d exp 255", mem_if.addr_r_out); end
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL edges_px: got %h exp %h", o, e); end
        end
        total++; if (underflow_out !== 1'b0) begin bad++; $display("FAIL edges_underflow: got %b exp 0", underflow_out); end
    endtask

    task automatic test_underflow();
        vid_t e, o;
        cursor_x_in = 6'd50;
        cursor_y_in = 6'd50;
        run_line(23, 0, 4'b0000);
        // Next line starts past the prefetch point, so the first word is missing.
        for (int h = 62; h < H_TOTAL; h++) begin
            tick(h, 24, (h >= 345 && h < 375) ? 1'b0 : 1'b1, 1'b1, (h >= 330), 4'b0001);
            total++;
            if (underflow_out !== (h >= 64)) begin
                bad++;
                $display("FAIL underflow_flag h=%0d: got %b exp %b", h, underflow_out, (h >= 64));
            end
        end
        run_line(25, 0, 4'b0000);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL underflow_px: got %h exp %h", o, e); end
        end
        total++; if (underflow_out !== 1'b1) begin bad++; $display("FAIL underflow_sticky: got %b exp 1", underflow_out); end
        do_reset(0, 300);
        total++; if (underflow_out !== 1'b0) begin bad++; $display("FAIL underflow_clear: got %b exp 0", underflow_out); end
    endtask

    task automatic test_reset_midline();
        vid_t e, o;
        for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
        run_line(16, 0, 4'b0000);
        for (int h = 0; h < 100; h++)
            tick(h, 17, 1'b1, 1'b1, 1'b0, 4'b0000);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL midline_pre_px: got %h exp %h", o, e); end
        end
        total++; if (mem_if.addr_r_out !== 8'd1) begin bad++; $display("FAIL midline_pre_addr: got %0d exp 1", mem_if.addr_r_out); end
        do_reset(100, 17);
        total++; if (pixel_out !== 12'h000) begin bad++; $display("FAIL midline_pixel: got %h exp 000", pixel_out); end
        total++; if (blank_out !== 1'b1) begin bad++; $display("FAIL midline_blank: got %b exp 1", blank_out); end
        total++; if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin bad++; $display("FAIL midline_sync: got %b%b exp 11", hsync_out, vsync_out); end
        total++; if (mem_if.addr_r_out !== 8'd0) begin bad++; $display("FAIL midline_addr: got %0d exp 0", mem_if.addr_r_out); end
        // Rest of the interrupted line shows empty cells; the next line is whole again.
        run_line(17, 101, 4'b1111);
        run_line(18, 0, 4'b0000);
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin bad++; $display("FAIL midline_post_px: got %h exp %h", o, e); end
        end
        total++; if (underflow_out !== 1'b0) begin bad++; $display("FAIL midline_underflow: got %b exp 0", underflow_out); end
    endtask

    initial begin
        rst_in      = 1'b1;
        hcount_in   = '0;
        vcount_in   = '0;
        hsync_in    = 1'b1;
        vsync_in    = 1'b1;
        blank_in    = 1'b1;
        cursor_x_in = 6'd63;
        cursor_y_in = 6'd63;
        for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
        test_reset();
        test_pattern();
        test_row_addr();
        test_cursor();
        test_sync_pass();
        test_edges();
        test_underflow();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
